// File: rtl/dmem_mmio.sv
// Data-side memory for the single-cycle core: a word-addressed RAM plus a
// memory-mapped GPIO / cycle-counter / timer page, read combinationally.
module dmem_mmio #(
  parameter int unsigned RAM_WORDS = 64,
  parameter int unsigned GPIO_W    = 8,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [31:0]       addr,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  localparam logic [5:0] R_GPIO_OUT = 6'h00;
  localparam logic [5:0] R_GPIO_IN  = 6'h01;
  localparam logic [5:0] R_CYCLE    = 6'h02;
  localparam logic [5:0] R_LOAD     = 6'h03;
  localparam logic [5:0] R_CTRL     = 6'h04;
  localparam logic [5:0] R_STATUS   = 6'h05;
  localparam logic [5:0] R_COUNT    = 6'h06;

  logic [31:0]       mem_q [RAM_WORDS];
  logic              ram_hit;
  logic              mmio_hit;
  logic [AW-1:0]     ram_idx;
  logic [5:0]        sel;
  logic              wr_mmio;
  logic              wr_gpio;
  logic              wr_load;
  logic              wr_ctrl;
  logic              wr_status;
  logic              unused_addr;

  logic [GPIO_W-1:0] gpio_out_q;
  logic [GPIO_W-1:0] sync1_q;
  logic [GPIO_W-1:0] sync2_q;
  logic [31:0]       cycle_q;
  logic [31:0]       load_q;
  logic [2:0]        ctrl_q;
  logic [31:0]       count_q;
  logic [31:0]       count_d;
  logic              expired_q;
  logic              expired_d;

  assign ram_hit     = {2'b00, addr[31:2]} < RAM_WORDS;
  assign mmio_hit    = addr[31:8] == MMIO_BASE[31:8];
  assign ram_idx     = addr[AW+1:2];
  assign sel         = addr[7:2];
  assign unused_addr = ^addr[1:0];

  assign wr_mmio   = memwrite & mmio_hit;
  assign wr_gpio   = wr_mmio && (sel == R_GPIO_OUT);
  assign wr_load   = wr_mmio && (sel == R_LOAD);
  assign wr_ctrl   = wr_mmio && (sel == R_CTRL);
  assign wr_status = wr_mmio && (sel == R_STATUS);

  // RAM has no reset; a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (memwrite && ram_hit) mem_q[ram_idx] <= writedata;
  end

  // Load beats decrement; an expiry in the same cycle as a W1C keeps expired set.
  always_comb begin
    count_d   = count_q;
    expired_d = expired_q;
    if (wr_status && writedata[0]) expired_d = 1'b0;
    if (wr_load) begin
      count_d = writedata;
    end else if (ctrl_q[0]) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else if (count_q == 32'd1) begin
        count_d   = ctrl_q[1] ? load_q : '0;
        expired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      cycle_q    <= '0;
      load_q     <= '0;
      ctrl_q     <= '0;
      count_q    <= '0;
      expired_q  <= 1'b0;
    end else begin
      sync1_q   <= gpio_in;
      sync2_q   <= sync1_q;
      cycle_q   <= cycle_q + 32'd1;
      count_q   <= count_d;
      expired_q <= expired_d;
      if (wr_gpio) gpio_out_q <= writedata[GPIO_W-1:0];
      if (wr_load) load_q     <= writedata;
      if (wr_ctrl) ctrl_q     <= writedata[2:0];
    end
  end

  always_comb begin
    readdata = '0;
    if (ram_hit) begin
      readdata = mem_q[ram_idx];
    end else if (mmio_hit) begin
      case (sel)
        R_GPIO_OUT: readdata = 32'(gpio_out_q);
        R_GPIO_IN:  readdata = 32'(sync2_q);
        R_CYCLE:    readdata = cycle_q;
        R_LOAD:     readdata = load_q;
        R_CTRL:     readdata = {29'b0, ctrl_q};
        R_STATUS:   readdata = {31'b0, expired_q};
        R_COUNT:    readdata = count_q;
        default:    readdata = '0;
      endcase
    end
  end

  assign gpio_out = gpio_out_q;
  assign irq      = expired_q & ctrl_q[2];

endmodule
